// File: rtl/frame_timing_gen_pkg.sv
// Shared definitions for the frame timing generator: FSM state encoding,
// index/frame-count widths and the phase-counter reload helper.
package frame_timing_gen_pkg;

    localparam int IDX_W  = 16;
    localparam int FCNT_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FV_SETUP  = 3'd1,
        ST_LINE      = 3'd2,
        ST_LINE_GAP  = 3'd3,
        ST_FV_HOLD   = 3'd4,
        ST_FRAME_GAP = 3'd5
    } state_e;

    // A phase of n cycles loads n-1; the counter reports zero on its last cycle.
    function automatic logic [IDX_W-1:0] reload(input int n);
        return IDX_W'(n - 1);
    endfunction

endpackage

// File: rtl/frame_timing_gen_if.sv
// Framing bus between the timing generator (master) and the pattern stage (slave).
interface frame_timing_gen_if;
    import frame_timing_gen_pkg::*;

    logic              enable;
    logic              fval;
    logic              lval;
    logic              dval;
    logic              lval_negedge;
    logic              fval_posedge;
    logic [IDX_W-1:0]  col_idx;
    logic [IDX_W-1:0]  row_idx;
    logic              busy;
    logic [FCNT_W-1:0] frame_count;

    modport master (
        input  enable,
        output fval, lval, dval, lval_negedge, fval_posedge,
               col_idx, row_idx, busy, frame_count
    );

    modport slave (
        output enable,
        input  fval, lval, dval, lval_negedge, fval_posedge,
               col_idx, row_idx, busy, frame_count
    );

endinterface

// File: rtl/frame_timing_gen_timing_down_counter.sv
// Loadable down-counter that times each FSM phase; saturates at zero.
module frame_timing_gen_timing_down_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic [W-1:0] value_o,
    output logic         zero_o
);

    logic [W-1:0] value_q, value_d;

    // Load on phase entry, otherwise count down and park at zero.
    always_comb begin
        value_d = value_q;
        if (load_i) begin
            value_d = load_val_i;
        end else if (value_q != '0) begin
            value_d = value_q - W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o = value_q;
    assign zero_o  = (value_q == '0);

endmodule

// File: rtl/frame_timing_gen.sv
// Camera-link style frame timing source: FVAL/LVAL/DVAL framing, single-cycle
// lval_negedge / fval_posedge strobes, pixel/line indices. All outputs are
// flops loaded from the next-state decode.
// Optional feature: define FRAME_COUNT_EN to build the completed-frame counter;
// otherwise frame_count is tied to zero.
module frame_timing_gen
    import frame_timing_gen_pkg::*;
#(
    parameter int DVAL_HIGH = 640,
    parameter int ROW_COUNT = 480,
    parameter int LINE_GAP  = 32,
    parameter int FV_TO_LV  = 4,
    parameter int LV_TO_FV  = 4,
    parameter int FRAME_GAP = 64
) (
    input  logic clk,
    input  logic rst,
    frame_timing_gen_if.master tim
);

    if (DVAL_HIGH < 1 || DVAL_HIGH > 65535 || ROW_COUNT < 1 || ROW_COUNT > 65535 ||
        LINE_GAP  < 1 || LINE_GAP  > 65535 || FV_TO_LV  < 1 || FV_TO_LV  > 65535 ||
        LV_TO_FV  < 1 || LV_TO_FV  > 65535 || FRAME_GAP < 1 || FRAME_GAP > 65535) begin : g_bad_param
        $error("frame_timing_gen: every timing parameter must be in 1..65535");
    end

    state_e           state_q, state_d;
    logic             cnt_load;
    logic [IDX_W-1:0] cnt_load_val;
    logic             cnt_zero;
    logic [IDX_W-1:0] phase_value_unused;

    logic             fval_q, fval_d;
    logic             lval_q, lval_d;
    logic             lneg_q, lneg_d;
    logic             fpos_q, fpos_d;
    logic             busy_q, busy_d;
    logic [IDX_W-1:0] col_q, col_d;
    logic [IDX_W-1:0] row_q, row_d;

    frame_timing_gen_timing_down_counter #(.W(IDX_W)) u_phase (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .value_o    (phase_value_unused),
        .zero_o     (cnt_zero)
    );

    // State and output registers; reset aborts a frame without strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            fval_q  <= 1'b0;
            lval_q  <= 1'b0;
            lneg_q  <= 1'b0;
            fpos_q  <= 1'b0;
            busy_q  <= 1'b0;
            col_q   <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            fval_q  <= fval_d;
            lval_q  <= lval_d;
            lneg_q  <= lneg_d;
            fpos_q  <= fpos_d;
            busy_q  <= busy_d;
            col_q   <= col_d;
            row_q   <= row_d;
        end
    end

    // Next state; the phase counter is reloaded on every state entry.
    always_comb begin
        state_d      = state_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (tim.enable) begin
                    state_d      = ST_FV_SETUP;
                    cnt_load     = 1'b1;
                    cnt_load_val = reload(FV_TO_LV);
                end
            end
            ST_FV_SETUP: begin
                if (cnt_zero) begin
                    state_d      = ST_LINE;
                    cnt_load     = 1'b1;
                    cnt_load_val = reload(DVAL_HIGH);
                end
            end
            ST_LINE: begin
                if (cnt_zero) begin
                    cnt_load = 1'b1;
                    if (row_q == IDX_W'(ROW_COUNT - 1)) begin
                        state_d      = ST_FV_HOLD;
                        cnt_load_val = reload(LV_TO_FV);
                    end else begin
                        state_d      = ST_LINE_GAP;
                        cnt_load_val = reload(LINE_GAP);
                    end
                end
            end
            ST_LINE_GAP: begin
                if (cnt_zero) begin
                    state_d      = ST_LINE;
                    cnt_load     = 1'b1;
                    cnt_load_val = reload(DVAL_HIGH);
                end
            end
            ST_FV_HOLD: begin
                if (cnt_zero) begin
                    state_d      = ST_FRAME_GAP;
                    cnt_load     = 1'b1;
                    cnt_load_val = reload(FRAME_GAP);
                end
            end
            ST_FRAME_GAP: begin
                // enable only matters here and in IDLE, so frames are never truncated.
                if (cnt_zero) begin
                    if (tim.enable) begin
                        state_d      = ST_FV_SETUP;
                        cnt_load     = 1'b1;
                        cnt_load_val = reload(FV_TO_LV);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode from the upcoming state so every output leaves a flop.
    always_comb begin
        fval_d = (state_d == ST_FV_SETUP) || (state_d == ST_LINE) ||
                 (state_d == ST_LINE_GAP) || (state_d == ST_FV_HOLD);
        lval_d = (state_d == ST_LINE);
        fpos_d = (state_d == ST_FV_SETUP) && (state_q != ST_FV_SETUP);
        lneg_d = (state_q == ST_LINE) && (state_d != ST_LINE);
        busy_d = (state_d != ST_IDLE);
        col_d  = ((state_d == ST_LINE) && (state_q == ST_LINE)) ? col_q + IDX_W'(1) : '0;
        if ((state_d == ST_IDLE) || (state_d == ST_FV_SETUP) || (state_d == ST_FRAME_GAP)) begin
            row_d = '0;
        end else if ((state_q == ST_LINE_GAP) && (state_d == ST_LINE)) begin
            row_d = row_q + IDX_W'(1);
        end else begin
            row_d = row_q;
        end
    end

`ifdef FRAME_COUNT_EN
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;

    // A frame counts as complete when FV_HOLD hands over to FRAME_GAP.
    always_comb begin
        fcnt_d = fcnt_q;
        if ((state_q == ST_FV_HOLD) && (state_d == ST_FRAME_GAP)) begin
            fcnt_d = fcnt_q + FCNT_W'(1);
        end
    end

    // Completed-frame counter, wraps naturally, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            fcnt_q <= '0;
        end else begin
            fcnt_q <= fcnt_d;
        end
    end

    assign tim.frame_count = fcnt_q;
`else
    assign tim.frame_count = '0;
`endif

    assign tim.fval         = fval_q;
    assign tim.lval         = lval_q;
    assign tim.dval         = lval_q;
    assign tim.lval_negedge = lneg_q;
    assign tim.fval_posedge = fpos_q;
    assign tim.busy         = busy_q;
    assign tim.col_idx      = col_q;
    assign tim.row_idx      = row_q;

endmodule

// File: tb/tb_frame_timing_gen.sv
// Directed bench: DUT A uses the 8x4 bench geometry (50-cycle frame),
// DUT B the 1x1 corner case. Frame cycle c=0 is the fval_posedge cycle.
module tb_frame_timing_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

`ifdef FRAME_COUNT_EN
    localparam bit FC_EN = 1'b1;
`else
    localparam bit FC_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    frame_timing_gen_if a_if();
    frame_timing_gen_if b_if();

    frame_timing_gen #(
        .DVAL_HIGH(8), .ROW_COUNT(4), .LINE_GAP(3),
        .FV_TO_LV(2), .LV_TO_FV(2), .FRAME_GAP(5)
    ) u_a (
        .clk (clk),
        .rst (rst),
        .tim (a_if.master)
    );

    frame_timing_gen #(
        .DVAL_HIGH(1), .ROW_COUNT(1), .LINE_GAP(3),
        .FV_TO_LV(2), .LV_TO_FV(2), .FRAME_GAP(5)
    ) u_b (
        .clk (clk),
        .rst (rst),
        .tim (b_if.master)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] fc_exp(input int n);
        return FC_EN ? 32'(n) : 32'd0;
    endfunction

    // Walks DUT A from c=2 to c=49 and leaves the bench at c=50.
    task automatic run_frame(input int drop_at, input int fc_n);
        int nd = 0;
        int nn = 0;
        int np = 0;
        int k;
        logic exp_lv;
        logic exp_ln;
        for (int c = 2; c < 50; c++) begin
            if (c == drop_at) a_if.enable = 1'b0;
            k      = (c - 2) % 11;
            exp_lv = (c < 43) && (k < 8);
            exp_ln = (c >= 10) && (c <= 43) && (((c - 10) % 11) == 0);
            check("a_lval", 32'(a_if.lval), 32'(exp_lv));
            check("a_dval", 32'(a_if.dval), 32'(exp_lv));
            check("a_fval", 32'(a_if.fval), 32'(c < 45));
            check("a_lneg", 32'(a_if.lval_negedge), 32'(exp_ln));
            check("a_busy", 32'(a_if.busy), 32'd1);
            check("a_col", 32'(a_if.col_idx), exp_lv ? 32'(k) : 32'd0);
            check("a_row", 32'(a_if.row_idx), (c < 45) ? 32'((c - 2) / 11) : 32'd0);
            if (c == 44) check("a_fc_pre", a_if.frame_count, fc_exp(fc_n - 1));
            if (c == 45) check("a_fc_post", a_if.frame_count, fc_exp(fc_n));
            nd += int'(a_if.dval);
            nn += int'(a_if.lval_negedge);
            np += int'(a_if.fval_posedge);
            step();
        end
        check("a_dval_per_frame", 32'(nd), 32'd32);
        check("a_lneg_per_frame", 32'(nn), 32'd4);
        check("a_fpos_inside_frame", 32'(np), 32'd0);
    endtask

    initial begin
        int cnt_pos, cnt_busy, cnt_fv, cnt_dv, cnt_ln;
        a_if.enable = 1'b1;
        b_if.enable = 1'b0;

        // 1: reset with enable high, then release
        repeat (3) step();
        check("rst_a_flags", 32'({a_if.fval, a_if.lval, a_if.dval, a_if.lval_negedge,
                                 a_if.fval_posedge, a_if.busy}), 32'd0);
        check("rst_a_col", 32'(a_if.col_idx), 32'd0);
        check("rst_a_row", 32'(a_if.row_idx), 32'd0);
        check("rst_a_fc", a_if.frame_count, 32'd0);
        check("rst_b_busy", 32'(b_if.busy), 32'd0);
        rst = 1'b0;
        step();
        check("c0_fval", 32'(a_if.fval), 32'd1);
        check("c0_fpos", 32'(a_if.fval_posedge), 32'd1);
        check("c0_lval", 32'(a_if.lval), 32'd0);
        check("c0_busy", 32'(a_if.busy), 32'd1);
        step();
        check("c1_fpos", 32'(a_if.fval_posedge), 32'd0);
        check("c1_lval", 32'(a_if.lval), 32'd0);
        step();
        check("c2_lval_rise", 32'(a_if.lval), 32'd1);

        // 2: steady enable, full frame then next fval_posedge 50 cycles later
        run_frame(-1, 1);
        check("period_fpos", 32'(a_if.fval_posedge), 32'd1);
        check("period_fval", 32'(a_if.fval), 32'd1);
        step();
        step();

        // 3: drop enable during row 1; frame and its gap finish, then idle
        run_frame(15, 2);
        check("idle_fval", 32'(a_if.fval), 32'd0);
        check("idle_busy", 32'(a_if.busy), 32'd0);
        check("idle_fpos", 32'(a_if.fval_posedge), 32'd0);
        cnt_pos  = 0;
        cnt_busy = 0;
        repeat (60) begin
            step();
            cnt_pos  += int'(a_if.fval_posedge);
            cnt_busy += int'(a_if.busy);
        end
        check("idle_no_fpos", 32'(cnt_pos), 32'd0);
        check("idle_no_busy", 32'(cnt_busy), 32'd0);

        // 4: one-cycle reset mid-line at col 5, then restart from row 0
        a_if.enable = 1'b1;
        step();
        check("r4_fpos", 32'(a_if.fval_posedge), 32'd1);
        repeat (7) step();
        check("r4_col5", 32'(a_if.col_idx), 32'd5);
        check("r4_row0", 32'(a_if.row_idx), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("r4_flags", 32'({a_if.fval, a_if.lval, a_if.dval, a_if.fval_posedge, a_if.busy}), 32'd0);
        check("r4_no_lneg", 32'(a_if.lval_negedge), 32'd0);
        check("r4_col", 32'(a_if.col_idx), 32'd0);
        check("r4_fc", a_if.frame_count, 32'd0);
        step();
        check("r4_restart_fpos", 32'(a_if.fval_posedge), 32'd1);
        check("r4_restart_row", 32'(a_if.row_idx), 32'd0);
        step();
        step();
        run_frame(-1, 1);

        // 6: frame_count over three completed frames after reset
        step();
        step();
        run_frame(-1, 2);
        step();
        step();
        run_frame(20, 3);
        check("fc_after_3", a_if.frame_count, fc_exp(3));
        check("a_idle_end", 32'(a_if.busy), 32'd0);

        // 5: single-pixel, single-row frame on DUT B
        b_if.enable = 1'b1;
        step();
        b_if.enable = 1'b0;
        cnt_pos = 0;
        cnt_fv  = 0;
        cnt_dv  = 0;
        cnt_ln  = 0;
        for (int c = 0; c < 14; c++) begin
            if (c == 2) begin
                check("b_dval", 32'(b_if.dval), 32'd1);
                check("b_col", 32'(b_if.col_idx), 32'd0);
                check("b_row", 32'(b_if.row_idx), 32'd0);
            end
            if (c == 3) check("b_lneg", 32'({b_if.lval_negedge, b_if.fval}), 32'd3);
            if (c == 5) begin
                check("b_gap", 32'({b_if.fval, b_if.busy}), 32'd1);
                check("b_fc", b_if.frame_count, fc_exp(1));
            end
            if (c == 10) check("b_idle", 32'(b_if.busy), 32'd0);
            cnt_pos += int'(b_if.fval_posedge);
            cnt_fv  += int'(b_if.fval);
            cnt_dv  += int'(b_if.dval);
            cnt_ln  += int'(b_if.lval_negedge);
            step();
        end
        check("b_fpos_cnt", 32'(cnt_pos), 32'd1);
        check("b_fval_cycles", 32'(cnt_fv), 32'd5);
        check("b_dval_cycles", 32'(cnt_dv), 32'd1);
        check("b_lneg_cnt", 32'(cnt_ln), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
